// File: rtl/rv32_fetch_align.sv
// Fetch front-end: word fetches go into a circular halfword buffer, and one aligned RV32/RVC
// instruction is presented per handshake. Redirects, straddling 32-bit words and misaligned-PC faults are handled here.
module rv32_fetch_align #(
  parameter int          DEPTH          = 4,
  parameter bit          COMPRESSED_ISA = 1'b1,
  parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  output logic        insn_valid,
  output logic        insn_is_rvc,
  output logic        insn_fault,
  input  logic        insn_ready
);

  localparam int            PW        = $clog2(DEPTH);
  localparam int            CW        = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic          RST_FAULT = PROGADDR_RESET[0] | (~COMPRESSED_ISA & PROGADDR_RESET[1]);
  localparam logic          RST_SKIP  = COMPRESSED_ISA & PROGADDR_RESET[1];

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FLUSHWAIT} state_e;

  state_e                 state_q, state_d;
  logic [31:0]            fetch_addr_q, fetch_addr_d;
  logic [31:0]            pend_addr_q, pend_addr_d;
  logic                   skip_q, skip_d;
  logic                   fault_q, fault_d;
  logic [31:0]            pc_q, pc_d;
  logic [CW-1:0]          count_q, count_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0][15:0] buf_q;

  logic [15:0]   h0, h1;
  logic          head_rvc, head_ok, pop, push, flush_fault;
  logic [CW-1:0] pop_n, push_n, free, count_after;
  logic [PW-1:0] rd_ptr_p1, wr_ptr_p1;

  // Head decode; outputs depend only on registered state, so they hold while stalled.
  always_comb begin
    rd_ptr_p1   = rd_ptr_q + PW'(1);
    wr_ptr_p1   = wr_ptr_q + PW'(1);
    h0          = buf_q[rd_ptr_q];
    h1          = buf_q[rd_ptr_p1];
    head_rvc    = COMPRESSED_ISA && (h0[1:0] != 2'b11);
    head_ok     = head_rvc ? (count_q >= CW'(1)) : (count_q >= CW'(2));
    insn_valid  = fault_q | head_ok;
    insn_fault  = fault_q;
    insn_is_rvc = !fault_q && head_ok && head_rvc;
    insn_pc     = pc_q;
    if (fault_q || !head_ok) insn = 32'h0;
    else if (head_rvc)       insn = {16'h0, h0};
    else                     insn = {h1, h0};
    mem_valid   = (state_q != S_IDLE);
    mem_addr    = fetch_addr_q;
  end

  always_comb begin
    pop         = !fault_q && head_ok && insn_ready && !flush;
    push        = (state_q == S_REQ) && mem_ready && !flush;
    pop_n       = pop ? (head_rvc ? CW'(1) : CW'(2)) : '0;
    push_n      = push ? (skip_q ? CW'(1) : CW'(2)) : '0;
    count_after = count_q + push_n - pop_n;
    free        = DEPTH_C - count_q;
    flush_fault = flush_pc[0] | (~COMPRESSED_ISA & flush_pc[1]);
  end

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pend_addr_d  = pend_addr_q;
    skip_d       = skip_q;
    fault_d      = fault_q;
    count_d      = count_after;
    rd_ptr_d     = rd_ptr_q + pop_n[PW-1:0];
    wr_ptr_d     = wr_ptr_q + push_n[PW-1:0];
    pc_d         = pc_q + (pop ? (head_rvc ? 32'd2 : 32'd4) : 32'd0);
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      pc_d     = flush_pc;
      fault_d  = flush_fault;
      skip_d   = COMPRESSED_ISA & flush_pc[1];
      // An unaccepted request must stay on the bus; remember the new target until it completes.
      if (mem_valid && !mem_ready) begin
        state_d     = S_FLUSHWAIT;
        pend_addr_d = {flush_pc[31:2], 2'b00};
      end else begin
        fetch_addr_d = {flush_pc[31:2], 2'b00};
        state_d      = flush_fault ? S_IDLE : S_REQ;
      end
    end else begin
      case (state_q)
        S_IDLE:
          if (!fault_q && (free >= CW'(2) || (free >= CW'(1) && skip_q))) state_d = S_REQ;
        S_REQ:
          if (mem_ready) begin
            fetch_addr_d = fetch_addr_q + 32'd4;
            skip_d       = 1'b0;
            state_d      = ((DEPTH_C - count_after) >= CW'(2)) ? S_REQ : S_IDLE;
          end
        S_FLUSHWAIT:
          if (mem_ready) begin
            fetch_addr_d = pend_addr_q;
            state_d      = fault_q ? S_IDLE : S_REQ;
          end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= {PROGADDR_RESET[31:2], 2'b00};
      pend_addr_q  <= 32'h0;
      skip_q       <= RST_SKIP;
      fault_q      <= RST_FAULT;
      pc_q         <= PROGADDR_RESET;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pend_addr_q  <= pend_addr_d;
      skip_q       <= skip_d;
      fault_q      <= fault_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // Skip word carries only the upper halfword (PC entered mid-word).
  always_ff @(posedge clk) begin
    if (push) begin
      if (skip_q) begin
        buf_q[wr_ptr_q] <= mem_rdata[31:16];
      end else begin
        buf_q[wr_ptr_q]  <= mem_rdata[15:0];
        buf_q[wr_ptr_p1] <= mem_rdata[31:16];
      end
    end
  end

endmodule

// File: tb/tb_rv32_fetch_align.sv
// Bench for rv32_fetch_align: a program-level model walks the memory image from the expected PC
// and checks every accepted instruction, plus directed redirect, stall and fault scenarios.
module tb_rv32_fetch_align;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, mem_ready, flush, insn_valid, insn_is_rvc, insn_fault, insn_ready;
  logic [31:0] mem_addr, mem_rdata, flush_pc, insn, insn_pc;
  logic        mem_valid32, mem_ready32, flush32, insn_valid32, insn_is_rvc32, insn_fault32, insn_ready32;
  logic [31:0] mem_addr32, mem_rdata32, flush_pc32, insn32, insn_pc32;

  logic [31:0] mem [0:1023];

  int          checks = 0, errors = 0;
  int          mem_pct = 100, rdy_pct = 100;
  bit          mon_en = 1'b0;
  logic [31:0] exp_pc;
  bit          exp_fault;
  int          n_insn = 0;
  bit          prv_pend, prv_hold, prv_flush, prv_rvc;
  logic [31:0] prv_addr, prv_insn, prv_ipc;

  always #5 clk = ~clk;

  assign mem_rdata   = mem[mem_addr[11:2]];
  assign mem_rdata32 = mem[mem_addr32[11:2]];

  rv32_fetch_align #(.DEPTH(4), .COMPRESSED_ISA(1'b1), .PROGADDR_RESET(32'h0)) u_dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .flush(flush), .flush_pc(flush_pc),
    .insn(insn), .insn_pc(insn_pc), .insn_valid(insn_valid), .insn_is_rvc(insn_is_rvc),
    .insn_fault(insn_fault), .insn_ready(insn_ready)
  );

  rv32_fetch_align #(.DEPTH(4), .COMPRESSED_ISA(1'b0), .PROGADDR_RESET(32'h0)) u_dut32 (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid32), .mem_addr(mem_addr32), .mem_ready(mem_ready32), .mem_rdata(mem_rdata32),
    .flush(flush32), .flush_pc(flush_pc32),
    .insn(insn32), .insn_pc(insn_pc32), .insn_valid(insn_valid32), .insn_is_rvc(insn_is_rvc32),
    .insn_fault(insn_fault32), .insn_ready(insn_ready32)
  );

  function automatic logic [15:0] half_at(input logic [31:0] a);
    logic [31:0] w;
    w = mem[a[11:2]];
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  // Memory and consumer handshakes, randomised by percentage.
  always @(negedge clk) begin
    #1;
    mem_ready  = mem_valid && (int'($urandom_range(99)) < mem_pct);
    insn_ready = (int'($urandom_range(99)) < rdy_pct);
  end

  // Scoreboard: instruction stream from the program image, bus hold and output stability.
  always @(negedge clk) begin : monitor
    logic [15:0] h0;
    logic        rvc;
    logic [31:0] e_insn;
    #2;
    if (mon_en) begin
      if (prv_pend) begin
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== prv_addr) begin
          errors++;
          $display("FAIL mem_hold: valid=%b addr=%h, required valid=1 addr=%h", mem_valid, mem_addr, prv_addr);
        end
      end
      if (prv_hold) begin
        checks++;
        if (insn !== prv_insn || insn_pc !== prv_ipc || insn_is_rvc !== prv_rvc) begin
          errors++;
          $display("FAIL insn_stable: insn=%h pc=%h rvc=%b, required insn=%h pc=%h rvc=%b",
                   insn, insn_pc, insn_is_rvc, prv_insn, prv_ipc, prv_rvc);
        end
      end
      if (exp_fault) begin
        checks++;
        if (insn_valid !== 1'b1 || insn_fault !== 1'b1 || insn !== 32'h0) begin
          errors++;
          $display("FAIL fault_hold: valid=%b fault=%b insn=%h, required 1 1 00000000", insn_valid, insn_fault, insn);
        end
      end else begin
        if (prv_flush) begin
          checks++;
          if (insn_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_bubble: insn_valid=%b, required 0", insn_valid);
          end
        end
        if (insn_valid === 1'b1 && insn_ready && !flush) begin
          h0     = half_at(exp_pc);
          rvc    = (h0[1:0] != 2'b11);
          e_insn = rvc ? {16'h0, h0} : {half_at(exp_pc + 32'd2), h0};
          checks++;
          if (insn !== e_insn || insn_pc !== exp_pc || insn_is_rvc !== rvc || insn_fault !== 1'b0) begin
            errors++;
            $display("FAIL insn_stream: insn=%h pc=%h rvc=%b fault=%b, required insn=%h pc=%h rvc=%b fault=0",
                     insn, insn_pc, insn_is_rvc, insn_fault, e_insn, exp_pc, rvc);
          end
          exp_pc = exp_pc + (rvc ? 32'd2 : 32'd4);
          n_insn++;
        end
      end
      if (flush) begin
        exp_pc    = flush_pc;
        exp_fault = flush_pc[0];
      end
      prv_pend  = mem_valid && !mem_ready;
      prv_addr  = mem_addr;
      prv_hold  = insn_valid && !insn_ready && !flush && !exp_fault;
      prv_insn  = insn;
      prv_ipc   = insn_pc;
      prv_rvc   = insn_is_rvc;
      prv_flush = flush;
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    resetn = 1'b0;
    flush = 1'b0;
    flush32 = 1'b0;
    repeat (2) @(negedge clk);
    resetn    = 1'b1;
    exp_pc    = 32'h0;
    exp_fault = 1'b0;
    prv_pend  = 1'b0;
    prv_hold  = 1'b0;
    prv_flush = 1'b0;
    mon_en    = 1'b1;
  endtask

  task automatic wait_insns(input int n, input int budget);
    int target;
    int k;
    target = n_insn + n;
    k = 0;
    while (n_insn < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (n_insn < target) begin
      errors++;
      $display("FAIL progress: %0d of %0d insns within %0d cycles", n - (target - n_insn), n, budget);
    end
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (insn_valid !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Asynchronous reset while a request is outstanding.
  task automatic test_reset();
    int k;
    do_reset();
    mem_pct = 0;
    k = 0;
    while (mem_valid !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL first_request: mem_valid=%b, required 1", mem_valid);
    end
    mon_en = 1'b0;
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: valid=%b addr=%h, required 0 00000000", mem_valid, mem_addr);
    end
    checks++;
    if (insn_valid !== 1'b0 || insn_fault !== 1'b0 || insn_is_rvc !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b fault=%b rvc=%b, required 0 0 0", insn_valid, insn_fault, insn_is_rvc);
    end
    checks++;
    if (insn !== 32'h0 || insn_pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_insn: insn=%h pc=%h, required 00000000 00000000", insn, insn_pc);
    end
    checks++;
    if (insn_valid32 !== 1'b0 || insn_fault32 !== 1'b0 || mem_valid32 !== 1'b0) begin
      errors++;
      $display("FAIL reset_rv32: valid=%b fault=%b mem_valid=%b, required 0 0 0", insn_valid32, insn_fault32, mem_valid32);
    end
    mem_pct = 100;
  endtask

  task automatic test_nop();
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0000_0013;
    mem_pct = 100;
    rdy_pct = 100;
    do_reset();
    wait_valid(10);
    checks++;
    if (insn_valid !== 1'b1 || insn !== 32'h13 || insn_pc !== 32'h0 || insn_is_rvc !== 1'b0) begin
      errors++;
      $display("FAIL nop_first: valid=%b insn=%h pc=%h rvc=%b, required 1 00000013 00000000 0", insn_valid, insn, insn_pc, insn_is_rvc);
    end
    @(negedge clk);
    checks++;
    if (insn_valid !== 1'b1 || insn !== 32'h13 || insn_pc !== 32'h4 || insn_is_rvc !== 1'b0) begin
      errors++;
      $display("FAIL nop_second: valid=%b insn=%h pc=%h rvc=%b, required 1 00000013 00000004 0", insn_valid, insn, insn_pc, insn_is_rvc);
    end
  endtask

  task automatic test_rvc_straddle();
    logic [31:0] w;
    w = $urandom;
    mem[0] = 32'h0013_4501;
    mem[1] = w;
    do_reset();
    wait_valid(10);
    checks++;
    if (insn !== 32'h0000_4501 || insn_pc !== 32'h0 || insn_is_rvc !== 1'b1) begin
      errors++;
      $display("FAIL rvc_first: insn=%h pc=%h rvc=%b, required 00004501 00000000 1", insn, insn_pc, insn_is_rvc);
    end
    @(negedge clk);
    wait_valid(10);
    checks++;
    if (insn !== {w[15:0], 16'h0013} || insn_pc !== 32'h2 || insn_is_rvc !== 1'b0) begin
      errors++;
      $display("FAIL straddle: insn=%h pc=%h rvc=%b, required %h 00000002 0", insn, insn_pc, insn_is_rvc, {w[15:0], 16'h0013});
    end
  endtask

  task automatic test_skip();
    logic [15:0] lo;
    lo = 16'($urandom);
    @(negedge clk);
    mem[32'h40] = {16'h4505, lo};
    flush = 1'b1;
    flush_pc = 32'h102;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL skip_addr: valid=%b addr=%h, required 1 00000100", mem_valid, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (insn_valid !== 1'b1 || insn_pc !== 32'h102 || insn !== 32'h4505 || insn_is_rvc !== 1'b1) begin
      errors++;
      $display("FAIL skip_insn: valid=%b pc=%h insn=%h rvc=%b, required 1 00000102 00004505 1", insn_valid, insn_pc, insn, insn_is_rvc);
    end
    wait_insns(6, 40);
  endtask

  task automatic test_flushwait();
    logic [31:0] old;
    int k;
    @(negedge clk);
    mem_pct = 0;
    k = 0;
    while (mem_valid !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    old = mem_addr;
    flush = 1'b1;
    flush_pc = 32'h300;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== old || insn_valid !== 1'b0) begin
        errors++;
        $display("FAIL flushwait_hold: valid=%b addr=%h insn_valid=%b, required 1 %h 0", mem_valid, mem_addr, insn_valid, old);
      end
    end
    mem_pct = 100;
    @(negedge clk);
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h300) begin
      errors++;
      $display("FAIL flushwait_new: valid=%b addr=%h, required 1 00000300", mem_valid, mem_addr);
    end
    wait_insns(6, 40);
  endtask

  task automatic test_backpressure();
    logic dropped;
    @(negedge clk);
    rdy_pct = 0;
    flush = 1'b1;
    flush_pc = 32'h402;
    dropped = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      flush = 1'b0;
      if (i > 0 && mem_valid === 1'b0) dropped = 1'b1;
    end
    checks++;
    if (dropped !== 1'b1 || mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_stall: dropped=%b mem_valid=%b, required 1 0", dropped, mem_valid);
    end
    checks++;
    if (insn_valid !== 1'b1 || insn_pc !== 32'h402) begin
      errors++;
      $display("FAIL stall_head: valid=%b pc=%h, required 1 00000402", insn_valid, insn_pc);
    end
    rdy_pct = 100;
    wait_insns(10, 60);
  endtask

  task automatic test_fault();
    @(negedge clk);
    flush = 1'b1;
    flush_pc = 32'h101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (mem_valid !== 1'b0 || insn_fault !== 1'b1 || insn_valid !== 1'b1 || insn !== 32'h0) begin
        errors++;
        $display("FAIL fault_state: mem_valid=%b fault=%b valid=%b insn=%h, required 0 1 1 00000000",
                 mem_valid, insn_fault, insn_valid, insn);
      end
    end
    flush = 1'b1;
    flush_pc = 32'h200;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (insn_fault !== 1'b0 || mem_valid !== 1'b1) begin
      errors++;
      $display("FAIL fault_clear: fault=%b mem_valid=%b, required 0 1", insn_fault, mem_valid);
    end
    wait_insns(4, 40);
  endtask

  task automatic test_rv32only();
    logic [31:0] w;
    int k;
    @(negedge clk);
    rdy_pct = 0;
    flush32 = 1'b1;
    flush_pc32 = 32'h102;
    @(negedge clk);
    flush32 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (insn_fault32 !== 1'b1 || insn_valid32 !== 1'b1 || insn32 !== 32'h0 || mem_valid32 !== 1'b0) begin
        errors++;
        $display("FAIL rv32_fault: fault=%b valid=%b insn=%h mem_valid=%b, required 1 1 00000000 0",
                 insn_fault32, insn_valid32, insn32, mem_valid32);
      end
      @(negedge clk);
    end
    w = $urandom;
    mem[32'h1C0] = 32'h0000_4501;
    mem[32'h1C1] = w;
    flush32 = 1'b1;
    flush_pc32 = 32'h700;
    @(negedge clk);
    flush32 = 1'b0;
    k = 0;
    while (insn_valid32 !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (insn32 !== 32'h0000_4501 || insn_pc32 !== 32'h700 || insn_is_rvc32 !== 1'b0 || insn_fault32 !== 1'b0) begin
      errors++;
      $display("FAIL rv32_first: insn=%h pc=%h rvc=%b fault=%b, required 00004501 00000700 0 0",
               insn32, insn_pc32, insn_is_rvc32, insn_fault32);
    end
    @(negedge clk);
    k = 0;
    while (insn_valid32 !== 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (insn32 !== w || insn_pc32 !== 32'h704 || insn_is_rvc32 !== 1'b0) begin
      errors++;
      $display("FAIL rv32_second: insn=%h pc=%h rvc=%b, required %h 00000704 0", insn32, insn_pc32, insn_is_rvc32, w);
    end
    rdy_pct = 100;
  endtask

  task automatic rand_flush();
    logic [31:0] pc;
    pc = 32'($urandom_range(0, 32'hBFF)) & 32'hFFFF_FFFE;
    for (int i = 0; i < 64; i++) mem[(int'(pc[11:2]) + i) % 1024] = $urandom;
    flush = 1'b1;
    flush_pc = pc;
  endtask

  task automatic test_random();
    int n0;
    n0 = n_insn;
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      mem_pct = int'($urandom_range(20, 100));
      rdy_pct = int'($urandom_range(20, 100));
      rand_flush();
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        flush = 1'b0;
        if ($urandom_range(99) < 3) rand_flush();
      end
    end
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (n_insn - n0 < 100) begin
      errors++;
      $display("FAIL random_progress: %0d insns, required at least 100", n_insn - n0);
    end
  endtask

  initial begin
    resetn = 1'b0;
    flush = 1'b0;
    flush_pc = 32'h0;
    mem_ready = 1'b0;
    insn_ready = 1'b0;
    flush32 = 1'b0;
    flush_pc32 = 32'h0;
    mem_ready32 = 1'b1;
    insn_ready32 = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    test_reset();
    test_nop();
    test_rvc_straddle();
    test_skip();
    test_flushwait();
    test_backpressure();
    test_fault();
    test_rv32only();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
